pwm_peripheral: RTL
===================

// Module: pwm_peripheral
// PURPOSE
//   Register file plus 16-channel PWM generator; sits directly downstream of the SPI
//   peripheral and consumes its validated register writes (addr 0x00-0x04).
//   Holds output-enable, PWM-enable and duty-cycle registers; drives 16 outputs as
//   static low/high or a shared ~3 kHz PWM waveform with glitch-free duty updates.
// PARAMETERS
//   CLK_DIV   13   clk cycles per PWM tick (10 MHz / 13 / 255 = ~3.02 kHz period)
// PORTS
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous, active-low reset
//   wr_en         in   1   one-cycle write strobe from SPI peripheral
//   wr_addr       in   7   register address
//   wr_data       in   8   register write data
//   out           out  16  channel outputs
//   period_start  out  1   one-cycle pulse when PWM counter wraps to 0
// BEHAVIOUR
//   - Reset: all registers 0, duty_active 0, prescaler 0, pwm_cnt 0, out 0, period_start 0.
//   - Register map (written when wr_en=1): 0x00 en_out[7:0], 0x01 en_out[15:8],
//     0x02 en_pwm[7:0], 0x03 en_pwm[15:8], 0x04 duty. Addr > 0x04: write ignored,
//     no state change. Writes take effect on the clk edge where wr_en is sampled.
//   - Prescaler: counts 0..CLK_DIV-1, wraps to 0; tick=1 in the cycle prescaler==CLK_DIV-1.
//   - pwm_cnt: 8-bit, advances on tick, counts 0..254 then wraps to 0 (period 255 ticks).
//   - period_start: registered pulse, high for exactly one clk after pwm_cnt wraps 254->0.
//   - Shadow duty: on the wrap 254->0, duty_active <= duty (value held before any
//     same-cycle write; a write coinciding with the wrap applies next period).
//   - pwm_sig = (duty_active == 8'hFF) ? 1 : (pwm_cnt < duty_active); duty 0 -> always 0.
//   - out[i] registered: en_out[i]==0 -> 0; en_out[i]==1 & en_pwm[i]==0 -> 1;
//     en_out[i]==1 & en_pwm[i]==1 -> pwm_sig. One clk latency from register/sig change.
//   - Disabling a channel mid-period: out[i] goes 0 on next clk; no pulse completion.
//   - en_pwm/en_out changes are not shadowed (apply immediately); only duty is shadowed.
//   - Reset mid-period: everything returns to reset values asynchronously; counting
//     restarts from 0 on first clk after deassertion.
// STRUCTURE
//   - Shared package: register address constants (ADDR_EN_OUT_LO..ADDR_DUTY = 0x00..0x04),
//     MAX_ADDR = 7'h04, PWM_PERIOD = 255.
//   - One sub-module: pwm_timebase (prescaler + pwm_cnt + tick/wrap + duty shadow,
//     outputs pwm_sig and period_start). Register file and output mux stay in top.
// TESTING
//   - Reset: assert rst_n=0 mid-run -> out=0, period_start=0, all regs read back 0.
//   - Static: write 0x00=0xFF, 0x01=0x0F, 0x02/0x03=0 -> out=16'h0FFF constant.
//   - PWM 50%: en_out=0xFFFF, en_pwm=0xFFFF, duty=0x80 -> after next period_start, out
//     high 128 ticks (1664 clk), low 127 ticks (1651 clk); period = 3315 clk.
//   - Duty extremes: duty=0x00 -> out stays 0 whole period; duty=0xFF -> stays 1.
//   - Shadowing: duty 0x40 -> 0xC0 written mid-period -> current period keeps 64-tick
//     high time; next period (after period_start) shows 192-tick high time.
//   - Bad address: write addr 0x05 data 0xFF, then 0x7F -> no register or out change.

Source files
------------

// File: rtl/pwm_peripheral_pkg.sv
// Shared definitions for the PWM peripheral: register map, PWM period
// constants and the register-file layout.
package pwm_peripheral_pkg;

   // Register addresses as seen on the write port from the SPI peripheral
   localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
   localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
   localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
   localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
   localparam logic [6:0] ADDR_DUTY      = 7'h04;
   localparam logic [6:0] MAX_ADDR       = 7'h04;

   // PWM counter runs 0..PWM_PERIOD-1, one step per prescaler tick
   localparam int         PWM_PERIOD  = 255;
   localparam logic [7:0] PWM_CNT_MAX = 8'(PWM_PERIOD - 1);
   // Duty of all-ones means "always high", not "high for 255 of 255 ticks minus one"
   localparam logic [7:0] DUTY_FULL   = 8'hFF;

   typedef struct packed {
      logic [15:0] en_out;
      logic [15:0] en_pwm;
      logic [7:0]  duty;
   } pwm_regs_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: clock prescaler, 8-bit period counter, period-start
// pulse and the shadowed duty value that only changes on a period boundary,
// so a duty update never produces a truncated or stretched pulse.
module pwm_timebase
   import pwm_peripheral_pkg::*;
#(
   parameter int CLK_DIV = 13
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] duty,
   output logic       pwm_sig,
   output logic       period_start
);

   localparam int PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [PS_W-1:0] prescaler;
   logic [7:0]      pwm_cnt;
   logic [7:0]      duty_active;
   logic            tick;
   logic            wrap;

   assign tick = (prescaler == PS_W'(CLK_DIV - 1));
   assign wrap = tick && (pwm_cnt == PWM_CNT_MAX);

   // Prescaler: divides clk down to the PWM tick rate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // PWM counter: one step per tick, wraps after the last count of the period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (wrap) begin
         pwm_cnt <= '0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + 8'd1;
      end
   end

   // Period boundary: pulse period_start and latch the pending duty value;
   // a duty write landing on the wrap edge is seen here only next period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_start <= 1'b0;
         duty_active  <= '0;
      end else begin
         period_start <= wrap;
         if (wrap) begin
            duty_active <= duty;
         end
      end
   end

   assign pwm_sig = (duty_active == DUTY_FULL) || (pwm_cnt < duty_active);

endmodule

// File: rtl/pwm_peripheral.sv
// PWM peripheral top: register file fed by validated SPI writes, plus the
// per-channel output mux selecting static low, static high or the shared
// PWM waveform. Enable changes act immediately; only duty is shadowed.
module pwm_peripheral
   import pwm_peripheral_pkg::*;
#(
   parameter int CLK_DIV = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [6:0]  wr_addr,
   input  logic [7:0]  wr_data,
   output logic [15:0] out,
   output logic        period_start
);

   pwm_regs_t regs;
   logic      pwm_sig;

   // Register file: out-of-range addresses leave every register untouched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else if (wr_en && (wr_addr <= MAX_ADDR)) begin
         case (wr_addr)
            ADDR_EN_OUT_LO: regs.en_out[7:0]  <= wr_data;
            ADDR_EN_OUT_HI: regs.en_out[15:8] <= wr_data;
            ADDR_EN_PWM_LO: regs.en_pwm[7:0]  <= wr_data;
            ADDR_EN_PWM_HI: regs.en_pwm[15:8] <= wr_data;
            ADDR_DUTY:      regs.duty         <= wr_data;
            default:        ;
         endcase
      end
   end

   pwm_timebase #(
      .CLK_DIV (CLK_DIV)
   ) u_timebase (
      .clk          (clk),
      .rst_n        (rst_n),
      .duty         (regs.duty),
      .pwm_sig      (pwm_sig),
      .period_start (period_start)
   );

   // Output mux: disabled -> 0, enabled static -> 1, enabled PWM -> shared waveform
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= '0;
      end else begin
         out <= regs.en_out & (~regs.en_pwm | {16{pwm_sig}});
      end
   end

endmodule
